// File: rtl/pcp_fic_pkg.sv
// pcp_fic_pkg: shared widths, constants and sign-magnitude helper for the PCP-FIC datapath
package pcp_fic_pkg;

    localparam int SM_MAG_W = 8;
    localparam int RES_W    = 16;

    localparam logic [SM_MAG_W:0]   SM_ZERO    = 9'h000;
    localparam logic [SM_MAG_W-1:0] SM_MAX_MAG = 8'hFF;

    // Packs a sign bit and a magnitude into one sign-magnitude word.
    function automatic logic [SM_MAG_W:0] sm_sat(input logic sign, input logic [SM_MAG_W-1:0] mag);
        return {sign, mag};
    endfunction

endpackage

// File: rtl/sm_abs_ovf.sv
// sm_abs_ovf: combinational sign, absolute value and overflow flag of a two's-complement word
module sm_abs_ovf
    import pcp_fic_pkg::*;
#(
    parameter int IN_W  = RES_W,
    parameter int MAG_W = SM_MAG_W
) (
    input  logic [IN_W-1:0]  data_i,
    output logic             sign_o,
    output logic [MAG_W-1:0] mag_o,
    output logic             big_o
);

    localparam logic [IN_W-1:0] MAX_MAG = IN_W'((1 << MAG_W) - 1);

    logic [IN_W-1:0] abs_w;

    assign sign_o = data_i[IN_W-1];
    assign abs_w  = sign_o ? ~data_i + IN_W'(1) : data_i;
    assign mag_o  = abs_w[MAG_W-1:0];
    // the most-negative input negates to itself, so its top bit flags it as too big
    assign big_o  = (abs_w > MAX_MAG) | (sign_o & abs_w[IN_W-1]);

endmodule

// File: rtl/sm_pack_unit.sv
// sm_pack_unit: two-stage valid/ready pipeline packing two's-complement results into sign-magnitude
module sm_pack_unit
    import pcp_fic_pkg::*;
#(
    parameter int IN_W  = RES_W,
    parameter int MAG_W = SM_MAG_W,
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [MAG_W:0]   NR,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [MAG_W:0] NR_ZERO = (MAG_W+1)'(SM_ZERO);

    logic             sign_w, big_w;
    logic [MAG_W-1:0] mag_w;
    logic             vala_q, vala_d, sign_q, sign_d, big_q, big_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic             out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [MAG_W:0]   nr_q, nr_d, pack_w;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             advance, accept;

    sm_abs_ovf #(.IN_W(IN_W), .MAG_W(MAG_W)) u_abs (
        .data_i (in_data),
        .sign_o (sign_w),
        .mag_o  (mag_w),
        .big_o  (big_w)
    );

    assign advance   = !out_valid_q | out_ready;
    assign in_ready  = !vala_q | advance;
    assign accept    = in_valid & in_ready;
    assign NR        = nr_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign ovf_count = cnt_q;

    if (MAG_W == SM_MAG_W) begin : g_pkg
        assign pack_w = sm_sat(sign_q, (SAT && big_q) ? SM_MAX_MAG : mag_q);
    end else begin : g_gen
        assign pack_w = {sign_q, (SAT && big_q) ? {MAG_W{1'b1}} : mag_q};
    end

    // next state: stage A loads on accept, stage B on advance, counter saturates and clear wins
    always_comb begin
        vala_d      = accept ? 1'b1 : (advance ? 1'b0 : vala_q);
        sign_d      = accept ? sign_w : sign_q;
        mag_d       = accept ? mag_w : mag_q;
        big_d       = accept ? big_w : big_q;
        out_valid_d = advance ? vala_q : out_valid_q;
        nr_d        = (advance && vala_q) ? pack_w : nr_q;
        ovf_d       = (advance && vala_q) ? big_q : ovf_q;
        cnt_d       = clr_cnt ? '0 :
                      (out_valid_q && out_ready && ovf_q && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // pipeline and counter registers; reset empties the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vala_q      <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            big_q       <= 1'b0;
            out_valid_q <= 1'b0;
            nr_q        <= NR_ZERO;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            vala_q      <= vala_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            big_q       <= big_d;
            out_valid_q <= out_valid_d;
            nr_q        <= nr_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
